// File: rtl/pkt_attribute_arbiter_if.sv
// rtl/pkt_attribute_arbiter_if.sv - analyzer result bus and winner output stream of the attribute arbiter
interface pkt_attribute_arbiter_if #(
   parameter int NUM_ANALYZERS        = 4,
   parameter int ATTRIBUTE_DATA_WIDTH = 135
);
   localparam int WINNER_WIDTH = (NUM_ANALYZERS > 1) ? $clog2(NUM_ANALYZERS) : 1;

   logic [NUM_ANALYZERS-1:0]                      in_pkt_valid;
   logic [NUM_ANALYZERS*ATTRIBUTE_DATA_WIDTH-1:0] in_pkt_attributes;
   logic                                          out_valid;
   logic                                          out_ready;
   logic [ATTRIBUTE_DATA_WIDTH-1:0]               out_attributes;
   logic [WINNER_WIDTH-1:0]                       out_winner;

   modport master (
      output in_pkt_valid,
      output in_pkt_attributes,
      output out_ready,
      input  out_valid,
      input  out_attributes,
      input  out_winner
   );

   modport slave (
      input  in_pkt_valid,
      input  in_pkt_attributes,
      input  out_ready,
      output out_valid,
      output out_attributes,
      output out_winner
   );
endinterface

// File: rtl/pkt_attribute_arbiter.sv
// rtl/pkt_attribute_arbiter.sv - fixed-priority per-packet attribute arbiter with output FIFO
// Statistics counters are built only when PKT_ARB_STATS_EN is defined.
module pkt_attribute_arbiter #(
   parameter int NUM_ANALYZERS        = 4,
   parameter int ATTRIBUTE_DATA_WIDTH = 135,
   parameter int COLLECT_TIMEOUT      = 8,
   parameter int FIFO_DEPTH_BITS      = 2,
   parameter int STATS_WIDTH          = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   pkt_attribute_arbiter_if.slave bus,
   output logic [STATS_WIDTH-1:0] timeout_count,
   output logic [STATS_WIDTH-1:0] drop_count
);
   localparam int N            = NUM_ANALYZERS;
   localparam int W            = ATTRIBUTE_DATA_WIDTH;
   localparam int WINNER_WIDTH = (N > 1) ? $clog2(N) : 1;
   localparam int DEPTH        = 1 << FIFO_DEPTH_BITS;
   localparam logic [N-1:0] ALL_ONES = '1;
   localparam logic [7:0]   TIMER_LAST = 8'(COLLECT_TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, COLLECT, ISSUE} state_t;
   state_t state, state_next;

   logic [N-1:0] mask, seed_mask;
   logic [W-1:0] cap       [N];
   logic [W-1:0] seed_data [N];
   logic [7:0]   timer;

   logic [N-1:0] in_valid, dup, fresh, mask_collect, mask_reload;
   logic         timer_expired;
   logic         do_issue, timeout_hit;

   assign in_valid      = bus.in_pkt_valid;
   assign dup           = in_valid & mask;
   assign fresh         = in_valid & ~mask;
   assign mask_collect  = mask | in_valid;
   assign mask_reload   = seed_mask | in_valid;
   assign timer_expired = (timer == TIMER_LAST);

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (|in_valid) state_next = (in_valid == ALL_ONES) ? ISSUE : COLLECT;
         end
         COLLECT: begin
            if ((mask_collect == ALL_ONES) || timer_expired || (|dup)) state_next = ISSUE;
         end
         ISSUE: begin
            if (mask_reload == ALL_ONES) state_next = ISSUE;
            else if (|mask_reload)       state_next = COLLECT;
            else                         state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // A complete mask closes the collection normally, so it is never counted as a timeout.
   always_comb begin
      do_issue    = 1'b0;
      timeout_hit = 1'b0;
      case (state)
         COLLECT: timeout_hit = (mask_collect != ALL_ONES) && timer_expired;
         ISSUE:   do_issue    = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         mask      <= '0;
         seed_mask <= '0;
         timer     <= '0;
      end else begin
         case (state)
            IDLE: begin
               mask  <= in_valid;
               timer <= '0;
            end
            COLLECT: begin
               mask      <= mask_collect;
               timer     <= timer + 8'd1;
               seed_mask <= seed_mask | dup;
            end
            ISSUE: begin
               mask      <= mask_reload;
               timer     <= '0;
               seed_mask <= seed_mask & in_valid;
            end
            default: ;
         endcase
      end
   end

   // A new report colliding with a seeded slot during ISSUE is parked as the next seed.
   always_ff @(posedge clk) begin
      for (int i = 0; i < N; i++) begin
         case (state)
            IDLE: begin
               if (in_valid[i]) cap[i] <= bus.in_pkt_attributes[i*W +: W];
            end
            COLLECT: begin
               if (fresh[i])    cap[i]       <= bus.in_pkt_attributes[i*W +: W];
               else if (dup[i]) seed_data[i] <= bus.in_pkt_attributes[i*W +: W];
            end
            ISSUE: begin
               if (seed_mask[i]) begin
                  cap[i] <= seed_data[i];
                  if (in_valid[i]) seed_data[i] <= bus.in_pkt_attributes[i*W +: W];
               end else if (in_valid[i]) begin
                  cap[i] <= bus.in_pkt_attributes[i*W +: W];
               end
            end
            default: ;
         endcase
      end
   end

   logic [WINNER_WIDTH-1:0] win_idx;
   logic [W-1:0]            win_data;

   always_comb begin
      win_idx  = '0;
      win_data = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (mask[i]) begin
            win_idx  = WINNER_WIDTH'(i);
            win_data = cap[i];
         end
      end
   end

   logic [W+WINNER_WIDTH-1:0] fifo_mem [DEPTH];
   logic [FIFO_DEPTH_BITS-1:0] wr_ptr, rd_ptr;
   logic [FIFO_DEPTH_BITS:0]   count;
   logic                       fifo_full, push, pop, drop;
   logic [W+WINNER_WIDTH-1:0]  head;

   assign fifo_full = (count == (FIFO_DEPTH_BITS + 1)'(DEPTH));
   assign pop       = bus.out_valid && bus.out_ready;
   assign push      = do_issue && (!fifo_full || pop);
   assign drop      = do_issue && fifo_full && !pop;

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + FIFO_DEPTH_BITS'(1);
         if (pop)  rd_ptr <= rd_ptr + FIFO_DEPTH_BITS'(1);
         case ({push, pop})
            2'b10:   count <= count + (FIFO_DEPTH_BITS + 1)'(1);
            2'b01:   count <= count - (FIFO_DEPTH_BITS + 1)'(1);
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr] <= {win_data, win_idx};
   end

   assign head               = fifo_mem[rd_ptr];
   assign bus.out_valid      = (count != '0);
   assign bus.out_attributes = bus.out_valid ? head[W+WINNER_WIDTH-1:WINNER_WIDTH] : '0;
   assign bus.out_winner     = bus.out_valid ? head[WINNER_WIDTH-1:0] : '0;

`ifdef PKT_ARB_STATS_EN
   logic [STATS_WIDTH-1:0] timeout_q, drop_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         timeout_q <= '0;
         drop_q    <= '0;
      end else begin
         if (timeout_hit && (timeout_q != '1)) timeout_q <= timeout_q + STATS_WIDTH'(1);
         if (drop && (drop_q != '1))           drop_q    <= drop_q + STATS_WIDTH'(1);
      end
   end

   assign timeout_count = timeout_q;
   assign drop_count    = drop_q;
`else
   logic unused_stats;
   assign unused_stats  = timeout_hit ^ drop;
   assign timeout_count = '0;
   assign drop_count    = '0;
`endif
endmodule

// File: tb/tb_pkt_attribute_arbiter.sv
// tb/tb_pkt_attribute_arbiter.sv - directed self-checking bench for pkt_attribute_arbiter
module tb_pkt_attribute_arbiter;
   localparam int N = 4;
   localparam int W = 135;
`ifdef PKT_ARB_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] timeout_count, drop_count;
   int          vectors = 0;
   int          miscompares = 0;

   pkt_attribute_arbiter_if #(.NUM_ANALYZERS(N), .ATTRIBUTE_DATA_WIDTH(W)) bus ();

   pkt_attribute_arbiter #(
      .NUM_ANALYZERS(N),
      .ATTRIBUTE_DATA_WIDTH(W),
      .COLLECT_TIMEOUT(8),
      .FIFO_DEPTH_BITS(2),
      .STATS_WIDTH(16)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus),
      .timeout_count(timeout_count),
      .drop_count(drop_count)
   );

   always #5 clk = ~clk;

   function automatic logic [W-1:0] word(int pkt, int an);
      return {7'(pkt), 64'hDEAD_BEEF_0000_0000 | 64'(an), 32'(pkt), 32'(an) ^ 32'h5A5A_0000};
   endfunction

   function automatic logic [15:0] cnt(int n);
      return STATS ? 16'(n) : 16'd0;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(string tag, logic [159:0] obs, logic [159:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic pulse(logic [N-1:0] v, int pkt);
      for (int i = 0; i < N; i++) bus.in_pkt_attributes[i*W +: W] = word(pkt, i);
      bus.in_pkt_valid = v;
      tick();
      bus.in_pkt_valid = '0;
   endtask

   task automatic head_is(string tag, int pkt, int an);
      chk({tag, "_valid"}, 160'(bus.out_valid), 160'd1);
      chk({tag, "_attr"}, 160'(bus.out_attributes), 160'(word(pkt, an)));
      chk({tag, "_winner"}, 160'(bus.out_winner), 160'(an));
   endtask

   initial begin
      reset                 = 1'b1;
      bus.in_pkt_valid      = '0;
      bus.in_pkt_attributes = '0;
      bus.out_ready         = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      chk("rst_valid", 160'(bus.out_valid), 160'd0);
      chk("rst_attr", 160'(bus.out_attributes), 160'd0);
      chk("rst_winner", 160'(bus.out_winner), 160'd0);
      chk("rst_timeouts", 160'(timeout_count), 160'd0);
      chk("rst_drops", 160'(drop_count), 160'd0);

      // all four analyzers report at staggered latencies
      pulse(4'b0001, 1);
      tick();
      pulse(4'b0010, 1);
      pulse(4'b0100, 1);
      tick();
      tick();
      pulse(4'b1000, 1);
      chk("full_issue_cycle", 160'(bus.out_valid), 160'd0);
      tick();
      head_is("full", 1, 0);
      chk("full_timeouts", 160'(timeout_count), 160'(cnt(0)));
      tick();
      chk("full_popped", 160'(bus.out_valid), 160'd0);

      // analyzers 2 and 3 only: collection closes by timeout
      pulse(4'b1100, 2);
      repeat (7) tick();
      chk("to_early", 160'(bus.out_valid), 160'd0);
      tick();
      chk("to_issue_cycle", 160'(bus.out_valid), 160'd0);
      chk("to_count", 160'(timeout_count), 160'(cnt(1)));
      tick();
      head_is("to", 2, 2);
      tick();
      chk("to_popped", 160'(bus.out_valid), 160'd0);

      // duplicate report from analyzer 3 starts the next packet
      pulse(4'b1000, 3);
      tick();
      pulse(4'b1000, 4);
      chk("dup_issue_cycle", 160'(bus.out_valid), 160'd0);
      tick();
      head_is("dup_first", 3, 3);
      tick();
      chk("dup_popped", 160'(bus.out_valid), 160'd0);
      repeat (7) tick();
      chk("dup_seed_wait", 160'(bus.out_valid), 160'd0);
      chk("dup_timeouts", 160'(timeout_count), 160'(cnt(2)));
      tick();
      head_is("dup_second", 4, 3);
      tick();
      chk("dup_second_popped", 160'(bus.out_valid), 160'd0);

      // six back-to-back complete packets into a stalled depth-4 FIFO
      bus.out_ready = 1'b0;
      for (int k = 0; k < 6; k++) pulse(4'b1111, 10 + k);
      tick();
      chk("drop_count", 160'(drop_count), 160'(cnt(2)));
      head_is("stall_a", 10, 0);
      tick();
      head_is("stall_b", 10, 0);
      bus.out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         head_is("drain", 10 + k, 0);
         tick();
      end
      chk("drain_empty", 160'(bus.out_valid), 160'd0);
      chk("drain_timeouts", 160'(timeout_count), 160'(cnt(2)));

      // reset in the middle of a collection holding analyzers 0 and 1
      pulse(4'b0011, 20);
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("midrst_timeouts", 160'(timeout_count), 160'd0);
      chk("midrst_drops", 160'(drop_count), 160'd0);
      for (int k = 0; k < 10; k++) begin
         tick();
         chk("midrst_silent", 160'(bus.out_valid), 160'd0);
      end
      pulse(4'b0110, 21);
      repeat (8) tick();
      chk("post_rst_timeouts", 160'(timeout_count), 160'(cnt(1)));
      tick();
      head_is("post_rst", 21, 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
